// File: rtl/wall_clock_ext.sv
// wall_clock_ext: prescaled HH:MM:SS wall clock with run/pause, validated load, 12/24h display and one-shot alarm
module wall_clock_ext #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       set_en,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       pm,
    output logic       tick_1s,
    output logic       alarm,
    output logic       set_err
);
    localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    logic [PW-1:0] presc;
    logic [4:0] hour_i, nh;
    logic [5:0] min_i, sec_i, nm, ns;
    logic term, set_ok, sec_wrap, min_wrap;
    // terminal prescaler count, load validity and the time one second ahead
    always_comb begin
        term     = run && (presc == PW'(TICKS_PER_SEC - 1));
        set_ok   = (set_hours < 5'd24) && (set_minutes < 6'd60) && (set_seconds < 6'd60);
        sec_wrap = sec_i == 6'd59;
        min_wrap = min_i == 6'd59;
        ns       = sec_wrap ? 6'd0 : sec_i + 6'd1;
        nm       = sec_wrap ? (min_wrap ? 6'd0 : min_i + 6'd1) : min_i;
        nh       = (sec_wrap && min_wrap) ? (hour_i == 5'd23 ? 5'd0 : hour_i + 5'd1) : hour_i;
    end
    // display mapping is combinational so a mode change shows immediately
    always_comb begin
        seconds = sec_i;
        minutes = min_i;
        pm      = hour_i >= 5'd12;
        hours   = !mode_12h ? hour_i : (hour_i == 5'd0 ? 5'd12 : (hour_i > 5'd12 ? hour_i - 5'd12 : hour_i));
    end
    // prescaler, time registers and one-cycle status pulses; loads beat the seconds tick
    always_ff @(posedge Clock) begin
        if (reset) begin
            presc   <= '0;
            hour_i  <= '0;
            min_i   <= '0;
            sec_i   <= '0;
            tick_1s <= 1'b0;
            alarm   <= 1'b0;
            set_err <= 1'b0;
        end else begin
            tick_1s <= 1'b0;
            alarm   <= 1'b0;
            set_err <= 1'b0;
            if (set_en) begin
                if (set_ok) begin
                    hour_i <= set_hours;
                    min_i  <= set_minutes;
                    sec_i  <= set_seconds;
                    presc  <= '0;
                end else begin
                    set_err <= 1'b1;
                end
            end else if (run) begin
                presc <= term ? '0 : presc + 1'b1;
                if (term) begin
                    hour_i  <= nh;
                    min_i   <= nm;
                    sec_i   <= ns;
                    tick_1s <= 1'b1;
                    alarm   <= alarm_en && (nh == alarm_hours) && (nm == alarm_minutes) && (ns == 6'd0);
                end
            end
        end
    end
endmodule
